// File: rtl/spi_frame_loader_if.sv
// Frame intake and CPU-memory write channel between the SPI slave, the loader and memory.
// The slave modport is the loader's view; master is the surrounding SPI slave plus memory side.
interface spi_frame_loader_if #(
  parameter int ADDR_W = 6
);
  logic              frame_valid;
  logic [39:0]       frame_data;
  logic              frame_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;

  modport master (
    output frame_valid, frame_data, mem_gnt,
    input  frame_ready, mem_req, mem_addr, mem_wdata
  );

  modport slave (
    input  frame_valid, frame_data, mem_gnt,
    output frame_ready, mem_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/spi_frame_loader.sv
// Buffers SPI command frames and turns WRITE frames into CPU-memory writes, plus CPU run/halt control.
// Push-to-mem_req is 3 cycles from an empty idle FIFO; frame_ready drops when DEPTH frames are held.
module spi_frame_loader #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  spi_frame_loader_if.slave bus,
  output logic              cpu_run,
  output logic              busy,
  output logic [7:0]        err_count
);
  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_INC  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_INC  = PTR_W'(1);

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_RUN   = 2'b10,
    CMD_HALT  = 2'b11
  } cmd_e;

  typedef struct packed {
    cmd_e        cmd;
    logic [5:0]  addr;
    logic [31:0] data;
  } frame_t;

  typedef enum logic [1:0] {IDLE, DECODE, ISSUE} state_e;

  frame_t            fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  frame_t            cmd_q;
  state_e            state;
  state_e            state_nxt;
  logic              push;
  logic              pop;
  logic              load_wr;
  logic              set_run;
  logic              clr_run;
  logic              reject;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  // frame_ready depends only on the registered count, never on frame_valid
  assign bus.frame_ready = (count < FULL_CNT);
  assign push            = bus.frame_valid && bus.frame_ready;
  assign busy            = (state != IDLE) || (count != '0);
  assign bus.mem_req     = (state == ISSUE);
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= frame_t'(bus.frame_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_INC;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_INC;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_INC;
        2'b01:   count <= count - CNT_INC;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_wr   = 1'b0;
    set_run   = 1'b0;
    clr_run   = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        state_nxt = IDLE;
        case (cmd_q.cmd)
          CMD_RUN:  set_run = 1'b1;
          CMD_HALT: clr_run = 1'b1;
          CMD_WRITE: begin
            // memory is only writable while the CPU is held
            if (cpu_run) begin
              reject = 1'b1;
            end else begin
              load_wr   = 1'b1;
              state_nxt = ISSUE;
            end
          end
          default: ;
        endcase
      end
      ISSUE: begin
        if (bus.mem_gnt) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q       <= '0;
      cpu_run     <= 1'b0;
      err_count   <= 8'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      if (pop) begin
        cmd_q <= fifo_mem[rd_ptr];
      end
      if (set_run) begin
        cpu_run <= 1'b1;
      end
      if (clr_run) begin
        cpu_run <= 1'b0;
      end
      if (reject && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      if (load_wr) begin
        mem_addr_q  <= cmd_q.addr[ADDR_W-1:0];
        mem_wdata_q <= cmd_q.data;
      end
    end
  end
endmodule

// File: tb/tb_spi_frame_loader.sv
// Randomized and directed bench for spi_frame_loader against a transaction-level command model.
module tb_spi_frame_loader;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_run;
  logic       busy;
  logic [7:0] err_count;

  spi_frame_loader_if #(.ADDR_W(ADDR_W)) bus ();

  spi_frame_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .cpu_run   (cpu_run),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic gnt_rand_en = 1'b0;
  logic gnt_manual  = 1'b0;
  logic gnt_rnd     = 1'b0;

  assign bus.mem_gnt = gnt_rand_en ? gnt_rnd : gnt_manual;

  always begin
    @(posedge clk);
    #1;
    gnt_rnd = 1'($urandom_range(0, 1));
  end

  // Reference model: the ordered list of writes memory should see, the run flag and the reject count
  logic [37:0] exp_q[$];
  logic [37:0] got_q[$];
  int          got_base;
  logic        m_run;
  int          m_err;
  int          req_cycles = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.mem_req) req_cycles++;
      if (bus.mem_req && bus.mem_gnt) got_q.push_back({bus.mem_addr, bus.mem_wdata});
    end
  end

  function automatic logic [39:0] mk(input logic [1:0] cmd, input logic [5:0] a, input logic [31:0] d);
    return {cmd, a, d};
  endfunction

  function automatic void model_apply(input logic [39:0] f);
    case (f[39:38])
      2'b01: begin
        if (m_run) begin
          if (m_err < 255) m_err++;
        end else begin
          exp_q.push_back(f[37:0]);
        end
      end
      2'b10:   m_run = 1'b1;
      2'b11:   m_run = 1'b0;
      default: ;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    got_base = got_q.size();
    m_run    = 1'b0;
    m_err    = 0;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.frame_valid = 1'b0;
    bus.frame_data  = '0;
    gnt_rand_en     = 1'b0;
    gnt_manual      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic push_frame(input logic [39:0] f, output int waited);
    int   budget = 2000;
    logic acc;
    waited          = 0;
    bus.frame_valid = 1'b1;
    bus.frame_data  = f;
    do begin
      acc = bus.frame_ready;
      tick();
      if (!acc) waited++;
      budget--;
    end while (!acc && budget > 0);
    bus.frame_valid = 1'b0;
    if (!acc) check("push_timeout", 0, 1);
    else model_apply(f);
  endtask

  task automatic drain(input string tag);
    int budget = 5000;
    while (busy && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_idle"}, busy, 0);
    check({tag, "_nwr"}, got_q.size() - got_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
      check({tag, "_wr"}, got_q[got_base + i], exp_q[i]);
    end
    check({tag, "_err"}, err_count, m_err);
    check({tag, "_run"}, cpu_run, m_run);
    got_base = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int wsum;
    int rb;
    logic [39:0] f;
    int r;

    rst             = 1'b1;
    bus.frame_valid = 1'b0;
    bus.frame_data  = '0;
    got_base        = 0;
    m_run           = 1'b0;
    m_err           = 0;
    do_reset();

    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_err", err_count, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.frame_ready, 1);

    // Single WRITE: pushed at edge t, popped at t+1, DECODE in cycle t+2, mem_req visible from cycle t+3
    f = mk(2'b01, 6'h05, 32'hDEADBEEF);
    bus.frame_valid = 1'b1;
    bus.frame_data  = f;
    tick();
    bus.frame_valid = 1'b0;
    model_apply(f);
    check("lat_t0_req", bus.mem_req, 0);
    check("lat_t0_busy", busy, 1);
    tick();
    check("lat_t1_req", bus.mem_req, 0);
    tick();
    check("lat_t2_req", bus.mem_req, 1);
    check("lat_addr", bus.mem_addr, 6'h05);
    check("lat_wdata", bus.mem_wdata, 32'hDEADBEEF);
    tick();
    check("lat_hold_req", bus.mem_req, 1);
    check("lat_hold_wdata", bus.mem_wdata, 32'hDEADBEEF);
    gnt_manual = 1'b1;
    tick();
    gnt_manual = 1'b0;
    check("lat_drop_req", bus.mem_req, 0);
    drain("lat");

    // Full buffer: one write stuck in ISSUE plus DEPTH buffered frames
    gnt_manual = 1'b0;
    wsum = 0;
    for (int i = 0; i < 5; i++) begin
      push_frame(mk(2'b01, 6'(i + 8), $urandom()), w);
      wsum += w;
    end
    check("full_nowait", wsum, 0);
    check("full_ready", bus.frame_ready, 0);
    check("full_req", bus.mem_req, 1);
    check("full_addr", bus.mem_addr, 6'd8);
    f = mk(2'b01, 6'h3F, $urandom());
    bus.frame_valid = 1'b1;
    bus.frame_data  = f;
    repeat (3) tick();
    check("full_hold_ready", bus.frame_ready, 0);
    check("full_hold_addr", bus.mem_addr, 6'd8);
    gnt_manual = 1'b1;
    push_frame(f, w);
    drain("full");

    // RUN, rejected WRITE, HALT, accepted WRITE
    push_frame(mk(2'b10, 6'h00, 32'h0), w);
    drain("run");
    check("run_flag", cpu_run, 1);
    rb = req_cycles;
    push_frame(mk(2'b01, 6'h11, 32'hCAFEF00D), w);
    drain("rej");
    check("rej_err", err_count, 1);
    check("rej_noreq", req_cycles - rb, 0);
    push_frame(mk(2'b11, 6'h00, 32'h0), w);
    drain("halt");
    check("halt_flag", cpu_run, 0);
    push_frame(mk(2'b01, 6'h2A, 32'h12345678), w);
    drain("wr2");

    // Reject counter saturation
    gnt_rand_en = 1'b1;
    push_frame(mk(2'b10, 6'h00, 32'h0), w);
    rb = req_cycles;
    for (int i = 0; i < 300; i++) push_frame(mk(2'b01, 6'($urandom()), $urandom()), w);
    drain("sat");
    check("sat_err", err_count, 255);
    check("sat_noreq", req_cycles - rb, 0);

    // Reset while ISSUE is stalled with two frames queued
    push_frame(mk(2'b11, 6'h00, 32'h0), w);
    drain("sat_halt");
    gnt_rand_en = 1'b0;
    gnt_manual  = 1'b0;
    for (int i = 0; i < 3; i++) push_frame(mk(2'b01, 6'(i + 20), $urandom()), w);
    check("rq_req_before", bus.mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check("rq_req", bus.mem_req, 0);
    check("rq_busy", busy, 0);
    check("rq_ready", bus.frame_ready, 1);
    check("rq_err", err_count, 0);
    rb = req_cycles;
    gnt_manual = 1'b1;
    repeat (10) tick();
    check("rq_noreq", req_cycles - rb, 0);
    check("rq_busy_after", busy, 0);
    check("rq_nwr", got_q.size() - got_base, 0);

    // Push and pop on the same edge while two frames are buffered
    gnt_manual = 1'b0;
    wsum = 0;
    push_frame(mk(2'b00, 6'h00, 32'h0), w);
    wsum += w;
    for (int i = 0; i < 3; i++) begin
      push_frame(mk(2'b01, 6'(i + 40), $urandom()), w);
      wsum += w;
    end
    check("pp_ready_cnt2", bus.frame_ready, 1);
    push_frame(mk(2'b01, 6'd43, $urandom()), w);
    wsum += w;
    check("pp_ready_cnt3", bus.frame_ready, 1);
    push_frame(mk(2'b01, 6'd44, $urandom()), w);
    wsum += w;
    check("pp_ready_cnt4", bus.frame_ready, 0);
    check("pp_nowait", wsum, 0);
    gnt_rand_en = 1'b1;
    drain("pp");

    // Random command mix with random grant timing
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 100; i++) begin
        r = int'($urandom_range(0, 9));
        if (r < 6)       f = mk(2'b01, 6'($urandom()), $urandom());
        else if (r == 6) f = mk(2'b00, 6'($urandom()), $urandom());
        else if (r == 7) f = mk(2'b10, 6'($urandom()), $urandom());
        else             f = mk(2'b11, 6'($urandom()), $urandom());
        push_frame(f, w);
        repeat ($urandom_range(0, 2)) tick();
      end
      drain("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_frame_loader.md
SPI_FRAME_LOADER -- requirements
Module: spi_frame_loader

Interface
REQ-001: Parameter DEPTH, default 4: number of 40-bit frame buffer entries; a power of two, at least 2.
REQ-002: Parameter ADDR_W, default 6: width of the CPU memory word address.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: frame_valid  input  1  upstream SPI slave presents a complete received frame.
REQ-006: frame_data  input  40  frame; [39:38] cmd, [37:32] word address (lower ADDR_W bits used), [31:0] data.
REQ-007: frame_ready  output  1  loader can accept a frame this cycle.
REQ-008: mem_req  output  1  write request to CPU memory.
REQ-009: mem_addr  output  ADDR_W  write word address.
REQ-010: mem_wdata  output  32  write data.
REQ-011: mem_gnt  input  1  memory accepts the write this cycle.
REQ-012: cpu_run  output  1  CPU release flag; 1 = CPU executing.
REQ-013: busy  output  1  frames pending or a command in progress.
REQ-014: err_count  output  8  count of rejected WRITE frames.

Function
REQ-015: Commands: 00 NOP, 01 WRITE, 10 RUN, 11 HALT.
REQ-016: A frame is pushed on any edge where frame_valid && frame_ready.
REQ-017: frame_ready = (entries < DEPTH).
- Registered count; no combinational path from frame_valid.
REQ-018: Buffer is FIFO-ordered; read/write pointers wrap modulo DEPTH.
REQ-019: Push and pop on the same edge leave count unchanged; both operations take effect.
REQ-020: FSM states: IDLE, DECODE, ISSUE.
REQ-021: IDLE with count > 0: pop head into the command register; next state DECODE.
REQ-022: IDLE with count == 0: remain IDLE.
REQ-023: DECODE, NOP: next state IDLE, no other effect.
REQ-024: DECODE, RUN: cpu_run <= 1; next state IDLE.
REQ-025: DECODE, HALT: cpu_run <= 0; next state IDLE.
REQ-026: DECODE, WRITE with cpu_run == 0: load mem_addr and mem_wdata from the command; next state ISSUE.
REQ-027: DECODE, WRITE with cpu_run == 1: reject; err_count += 1, saturating at 255; next state IDLE.
REQ-028: ISSUE: mem_req = 1 with mem_addr and mem_wdata held stable until the cycle mem_gnt = 1.
- That edge: next state IDLE; mem_req is 0 in the following cycle.
REQ-029: mem_gnt is ignored outside ISSUE.
REQ-030: Latency, empty FIFO, IDLE, frame pushed at edge t:
- pop at edge t+1;
- DECODE during cycle t+2;
- mem_req high from cycle t+3.
REQ-031: Back-to-back WRITE frames each take at least 3 cycles (IDLE, DECODE, ISSUE); throughput is one per 3 cycles when mem_gnt is held high.
REQ-032: busy = (state != IDLE) || (count != 0).
REQ-033: When full, frame_ready = 0 and a presented frame is not consumed; upstream holds it.

Reset
REQ-034: While rst = 1 at an edge:
- FIFO count and both pointers = 0; state = IDLE;
- mem_req = 0; mem_addr = 0; mem_wdata = 0;
- cpu_run = 0; err_count = 0; frame_ready = 1 from the next cycle.
REQ-035: rst dominates all other inputs, including during ISSUE.
- mem_req drops in the cycle after the reset edge.
- The pending write is discarded, not retried.

Verification
REQ-036: Reset, then WRITE addr 0x05 data 0xDEADBEEF -> mem_req rises 3 cycles after the push with mem_addr=0x05, mem_wdata=0xDEADBEEF; falls the cycle after mem_gnt.
REQ-037: Hold mem_gnt=0 and push 5 WRITEs with DEPTH=4 -> frame_ready=0 after 4 buffered entries plus 1 in ISSUE; release mem_gnt -> all 5 writes appear in push order.
REQ-038: RUN, then WRITE, then HALT, then WRITE -> cpu_run=1 after RUN; first WRITE rejected with err_count=1 and no mem_req; cpu_run=0 after HALT; second WRITE issued.
REQ-039: 300 rejected WRITEs while cpu_run=1 -> err_count saturates at 255.
REQ-040: Assert rst during ISSUE with mem_gnt=0 and 2 frames queued -> next cycle mem_req=0, busy=0, frame_ready=1; no further writes issued.
REQ-041: Push and pop on the same edge at count=2 -> count remains 2; pointers wrap correctly across more than DEPTH total frames.
